// File: rtl/rom_loader_if.sv
// rom_loader_if: connection between the HPS ioctl download port and the ROM
// loader, together with the byte-write bus that the loader drives toward
// the core's ROM/PROM memories.
//   ioctl_index/download/addr/dout/wr : HPS download word stream
//   ioctl_wait                        : loader busy, HPS must hold off
//   wr_en/wr_sel/wr_addr/wr_data      : one byte write per wr_en pulse
// Modports:
//   master : HPS/stimulus side (drives ioctl_*, observes the rest)
//   slave  : the loader itself
interface rom_loader_if #(
    parameter int NREG = 8,
    parameter int AW   = 16
);
    logic [7:0]      ioctl_index;
    logic            ioctl_download;
    logic [26:0]     ioctl_addr;
    logic [15:0]     ioctl_dout;
    logic            ioctl_wr;
    logic            ioctl_wait;
    logic            wr_en;
    logic [NREG-1:0] wr_sel;
    logic [AW-1:0]   wr_addr;
    logic [7:0]      wr_data;

    modport master (
        output ioctl_index, ioctl_download, ioctl_addr, ioctl_dout, ioctl_wr,
        input  ioctl_wait, wr_en, wr_sel, wr_addr, wr_data
    );

    modport slave (
        input  ioctl_index, ioctl_download, ioctl_addr, ioctl_dout, ioctl_wr,
        output ioctl_wait, wr_en, wr_sel, wr_addr, wr_data
    );
endinterface

// File: rtl/rom_loader.sv
// rom_loader: routes an HPS ioctl ROM download into NREG byte-addressed
// memory regions. Each accepted 16-bit word is split into an even-address
// byte and an odd-address byte, emitted on consecutive cycles. Each byte is
// looked up independently against the region table. The lowest-index
// matching region wins and receives a region-relative address. Bytes that
// hit no region are silently skipped.
// Ports:
//   clk_sys     : system clock
//   reset       : synchronous active-high reset
//   bus         : rom_loader_if.slave (ioctl stream in, byte writes out)
//   busy        : matching download active or a word still being emitted
//   done        : download finished since the last start
//   err_overrun : sticky, a word arrived while the previous one was pending
module rom_loader #(
    parameter int                 NREG      = 8,
    parameter int                 AW        = 16,
    parameter logic [7:0]         ROM_INDEX = 8'd0,
    parameter logic [27*NREG-1:0] REG_BASE  = {NREG{27'd0}},
    parameter logic [27*NREG-1:0] REG_SIZE  = {NREG{27'd0}},
    parameter bit                 SWAP      = 1'b0
) (
    input  logic          clk_sys,
    input  logic          reset,
    rom_loader_if.slave   bus,
    output logic          busy,
    output logic          done,
    output logic          err_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_B0   = 2'd1,
        ST_B1   = 2'd2
    } state_t;

    localparam logic [NREG-1:0] ONE_SEL = {{(NREG-1){1'b0}}, 1'b1};

    // Region bounds are widened to 28 bits so base + size can never wrap.
    function automatic logic [27:0] reg_base(input int idx);
        return {1'b0, REG_BASE[27*idx +: 27]};
    endfunction

    function automatic logic [27:0] reg_size(input int idx);
        return {1'b0, REG_SIZE[27*idx +: 27]};
    endfunction

    state_t          state_r;
    logic [15:0]     word_r;
    logic [26:0]     addr_r;
    logic            wait_r;
    logic            wr_en_r;
    logic [NREG-1:0] wr_sel_r;
    logic [AW-1:0]   wr_addr_r;
    logic [7:0]      wr_data_r;
    logic            busy_r;
    logic            done_r;
    logic            err_r;
    logic            seen_r;
    logic            dl_d_r;

    logic            dl_match_s;
    logic            acc_s;
    logic [26:0]     in_addr_s;
    logic [27:0]     lk_addr_s;
    logic [7:0]      lk_byte_s;
    logic [NREG-1:0] hit_s;
    logic [NREG-1:0] win_s;
    logic [AW-1:0]   rel_s;
    logic            emit_s;
    logic            idle_next_s;

    // Download qualification and word acceptance.
    always_comb begin
        dl_match_s = bus.ioctl_download & (bus.ioctl_index == ROM_INDEX);
        acc_s      = bus.ioctl_wr & dl_match_s;
        // An odd word address is a protocol violation; bit 0 is forced low.
        in_addr_s  = bus.ioctl_addr & 27'h7FF_FFFE;
    end

    // Select the byte being emitted next: the even byte comes straight from
    // the ioctl inputs on acceptance, the odd byte from the latched word.
    always_comb begin
        lk_addr_s = 28'd0;
        lk_byte_s = 8'd0;
        if (state_r == ST_IDLE) begin
            lk_addr_s = {1'b0, in_addr_s};
            lk_byte_s = SWAP ? bus.ioctl_dout[15:8] : bus.ioctl_dout[7:0];
        end else begin
            lk_addr_s = {1'b0, addr_r | 27'd1};
            lk_byte_s = SWAP ? word_r[7:0] : word_r[15:8];
        end
    end

    // Region lookup: hit vector, lowest-index winner, relative address.
    always_comb begin
        hit_s = '0;
        rel_s = '0;
        for (int i = 0; i < NREG; i++) begin
            hit_s[i] = (reg_size(i) != 28'd0) &&
                       (lk_addr_s >= reg_base(i)) &&
                       (lk_addr_s < (reg_base(i) + reg_size(i)));
        end
        // Isolate the lowest set bit so that overlaps resolve to region 0 first.
        win_s = hit_s & (~hit_s + ONE_SEL);
        for (int i = 0; i < NREG; i++) begin
            rel_s = rel_s | (win_s[i] ? AW'(lk_addr_s - reg_base(i)) : {AW{1'b0}});
        end
    end

    // Emission and next-state flags used by the registered outputs.
    always_comb begin
        emit_s      = ((state_r == ST_IDLE) & acc_s) | (state_r == ST_B0);
        idle_next_s = (state_r != ST_B0) & ~((state_r == ST_IDLE) & acc_s);
    end

    // Main FSM with all outputs registered.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            word_r    <= 16'd0;
            addr_r    <= 27'd0;
            wait_r    <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_sel_r  <= '0;
            wr_addr_r <= '0;
            wr_data_r <= 8'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            seen_r    <= 1'b0;
            dl_d_r    <= 1'b0;
        end else begin
            dl_d_r <= dl_match_s;
            busy_r <= dl_match_s | ~idle_next_s;

            // A new download start clears the completion and error flags;
            // done is only raised once the FSM is heading back to idle.
            if (dl_match_s & ~dl_d_r) begin
                seen_r <= 1'b1;
                done_r <= 1'b0;
                err_r  <= 1'b0;
            end else if (seen_r & ~dl_match_s & idle_next_s) begin
                done_r <= 1'b1;
            end else begin
                done_r <= done_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (acc_s) begin
                        word_r  <= bus.ioctl_dout;
                        addr_r  <= in_addr_s;
                        wait_r  <= 1'b1;
                        state_r <= ST_B0;
                    end else begin
                        wait_r  <= 1'b0;
                    end
                end
                ST_B0: begin
                    // A word arriving here is dropped; the pending one finishes.
                    if (acc_s) begin
                        err_r <= 1'b1;
                    end
                    state_r <= ST_B1;
                end
                ST_B1: begin
                    if (acc_s) begin
                        err_r <= 1'b1;
                    end
                    wait_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    wait_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase

            // Unmapped bytes leave the write bus holding its previous contents.
            if (emit_s & (|win_s)) begin
                wr_en_r   <= 1'b1;
                wr_sel_r  <= win_s;
                wr_addr_r <= rel_s;
                wr_data_r <= lk_byte_s;
            end else begin
                wr_en_r   <= 1'b0;
            end
        end
    end

    assign bus.ioctl_wait = wait_r;
    assign bus.wr_en      = wr_en_r;
    assign bus.wr_sel     = wr_sel_r;
    assign bus.wr_addr    = wr_addr_r;
    assign bus.wr_data    = wr_data_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign err_overrun    = err_r;

endmodule
